// File: rtl/fighter_action_scheduler.sv
// Frame-timed action sequencer for one fighter: free movement states,
// a three-phase attack, jump, parry with cooldown, and hit stun.
// All outputs come straight from flops updated with the state register.
module fighter_action_scheduler #(
  parameter int unsigned WINDUP_FRAMES  = 3,
  parameter int unsigned STRIKE_FRAMES  = 2,
  parameter int unsigned RECOVER_FRAMES = 4,
  parameter int unsigned JUMP_FRAMES    = 16,
  parameter int unsigned PARRY_FRAMES   = 6,
  parameter int unsigned PARRY_COOLDOWN = 20,
  parameter int unsigned STUN_FRAMES    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [6:0] ctrl_state,
  input  logic       hit_taken,
  output logic [3:0] action,
  output logic       move_left,
  output logic       move_right,
  output logic       hit_active,
  output logic       parry_active,
  output logic       parry_success,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WALK    = 4'd1,
    S_CROUCH  = 4'd2,
    S_JUMP    = 4'd3,
    S_WINDUP  = 4'd4,
    S_STRIKE  = 4'd5,
    S_RECOVER = 4'd6,
    S_PARRY   = 4'd7,
    S_STUN    = 4'd8
  } state_e;

  // Timed states are loaded with N-1 so that they last exactly N ticks.
  localparam logic [7:0] WINDUP_LOAD   = 8'(WINDUP_FRAMES - 1);
  localparam logic [7:0] STRIKE_LOAD   = 8'(STRIKE_FRAMES - 1);
  localparam logic [7:0] RECOVER_LOAD  = 8'(RECOVER_FRAMES - 1);
  localparam logic [7:0] JUMP_LOAD     = 8'(JUMP_FRAMES - 1);
  localparam logic [7:0] PARRY_LOAD    = 8'(PARRY_FRAMES - 1);
  localparam logic [7:0] STUN_LOAD     = 8'(STUN_FRAMES - 1);
  localparam logic [7:0] COOLDOWN_LOAD = 8'(PARRY_COOLDOWN);

  // Controller word decode; bit 0 carries no meaning for this block.
  logic btn_l, btn_r, btn_u, btn_d, btn_attack, btn_parry;
  logic unused_ctrl_bit0;
  assign btn_l            = ctrl_state[1];
  assign btn_r            = ctrl_state[2];
  assign btn_u            = ctrl_state[3];
  assign btn_d            = ctrl_state[4];
  assign btn_attack       = ctrl_state[5];
  assign btn_parry        = ctrl_state[6];
  assign unused_ctrl_bit0 = ctrl_state[0];

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] cooldown_q, cooldown_d;
  logic       attack_prev_q, attack_prev_d;
  logic       move_left_q, move_left_d;
  logic       move_right_q, move_right_d;
  logic       hit_active_q, hit_active_d;
  logic       parry_active_q, parry_active_d;
  logic       parry_success_q, parry_success_d;
  logic       busy_q, busy_d;
  logic       parry_ready;

  // A new parry is allowed on the tick that brings the cooldown to zero,
  // so a parry entered on tick 0 can be re-entered on tick PARRY_COOLDOWN.
  assign parry_ready = (cooldown_q <= 8'd1);

  // Next-state, counter, cooldown and registered-output computation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d         = state_q;
    frame_cnt_d     = frame_cnt_q;
    cooldown_d      = cooldown_q;
    attack_prev_d   = attack_prev_q;
    parry_success_d = 1'b0;

    // Edge history and cooldown advance on every tick, hit or not.
    if (tick) begin
      attack_prev_d = btn_attack;
      if (cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;
    end

    if (hit_taken) begin
      if (state_q == S_PARRY) begin
        // Absorbed hit: window keeps its count, but an expiring window still closes.
        parry_success_d = 1'b1;
        if (tick && frame_cnt_q == 8'd0) state_d = S_IDLE;
      end else begin
        state_d     = S_STUN;
        frame_cnt_d = STUN_LOAD;
      end
    end else if (tick) begin
      unique case (state_q)
        S_IDLE, S_WALK, S_CROUCH: begin
          frame_cnt_d = 8'd0;
          if (btn_parry && parry_ready) begin
            state_d     = S_PARRY;
            frame_cnt_d = PARRY_LOAD;
            cooldown_d  = COOLDOWN_LOAD;
          end else if (btn_attack && !attack_prev_q) begin
            state_d     = S_WINDUP;
            frame_cnt_d = WINDUP_LOAD;
          end else if (btn_u) begin
            state_d     = S_JUMP;
            frame_cnt_d = JUMP_LOAD;
          end else if (btn_d) begin
            state_d = S_CROUCH;
          end else if (btn_l || btn_r) begin
            state_d = S_WALK;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          if (frame_cnt_q != 8'd0) begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end else begin
            unique case (state_q)
              S_WINDUP: begin
                state_d     = S_STRIKE;
                frame_cnt_d = STRIKE_LOAD;
              end
              S_STRIKE: begin
                state_d     = S_RECOVER;
                frame_cnt_d = RECOVER_LOAD;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      endcase
    end

    // Outputs are decoded from the next state so they switch with it.
    move_left_d  = 1'b0;
    move_right_d = 1'b0;
    if (state_d == S_WALK || state_d == S_JUMP) begin
      move_left_d  = btn_l;
      move_right_d = btn_r & ~btn_l;
    end
    hit_active_d   = (state_d == S_STRIKE);
    parry_active_d = (state_d == S_PARRY);
    busy_d         = !(state_d == S_IDLE || state_d == S_WALK || state_d == S_CROUCH);
  end

  // State, timing and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      frame_cnt_q     <= 8'd0;
      cooldown_q      <= 8'd0;
      attack_prev_q   <= 1'b0;
      move_left_q     <= 1'b0;
      move_right_q    <= 1'b0;
      hit_active_q    <= 1'b0;
      parry_active_q  <= 1'b0;
      parry_success_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      frame_cnt_q     <= frame_cnt_d;
      cooldown_q      <= cooldown_d;
      attack_prev_q   <= attack_prev_d;
      move_left_q     <= move_left_d;
      move_right_q    <= move_right_d;
      hit_active_q    <= hit_active_d;
      parry_active_q  <= parry_active_d;
      parry_success_q <= parry_success_d;
      busy_q          <= busy_d;
    end
  end

  assign action        = state_q;
  assign move_left     = move_left_q;
  assign move_right    = move_right_q;
  assign hit_active    = hit_active_q;
  assign parry_active  = parry_active_q;
  assign parry_success = parry_success_q;
  assign busy          = busy_q;

endmodule
